// File: rtl/cbus_arbiter.sv
// Cache-bus arbiter: shares one cbus port between NUM_INPUTS masters and holds
// each grant until the final response beat (ready && last).
package cbus_pkg;
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [7:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;
endpackage

module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter int NUM_INPUTS     = 2,
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  ireqs  [NUM_INPUTS],
    output cbus_resp_t iresps [NUM_INPUTS],
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp
);

    localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e state_q, state_d;
    idx_t   index_q, index_d;
    idx_t   lastIndex_q, lastIndex_d;
    idx_t   winner;
    idx_t   candIdx;
    logic   anyValid;
    int     cand;

    // Round-robin scans upward from the master after the previous owner.
    always_comb begin
        anyValid = 1'b0;
        winner   = '0;
        candIdx  = '0;
        cand     = 0;
        if (FIXED_PRIORITY) begin
            for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
                candIdx = idx_t'(i);
                if (ireqs[candIdx].valid) begin
                    anyValid = 1'b1;
                    winner   = candIdx;
                end
            end
        end else begin
            for (int k = 1; k <= NUM_INPUTS; k++) begin
                cand    = (int'(lastIndex_q) + k) % NUM_INPUTS;
                candIdx = idx_t'(cand);
                if (!anyValid && ireqs[candIdx].valid) begin
                    anyValid = 1'b1;
                    winner   = candIdx;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        lastIndex_d = lastIndex_q;
        oreq        = '0;
        iresps      = '{default: '0};
        case (state_q)
            IDLE: begin
                if (anyValid) begin
                    state_d = BUSY;
                    index_d = winner;
                end
            end
            BUSY: begin
                oreq            = ireqs[index_q];
                iresps[index_q] = oresp;
                if (oresp.ready && oresp.last) begin
                    state_d     = IDLE;
                    lastIndex_d = index_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Last index resets to the top master so master 0 wins the first pick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            index_q     <= '0;
            lastIndex_q <= idx_t'(NUM_INPUTS - 1);
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            lastIndex_q <= lastIndex_d;
        end
    end

    logic [NUM_INPUTS-1:0] readyVec;
    for (genvar g = 0; g < NUM_INPUTS; g++) begin : gReady
        assign readyVec[g] = iresps[g].ready;
    end

    assert property (@(posedge clk) disable iff (reset) $onehot0(readyVec));
    assert property (@(posedge clk) disable iff (reset) (state_q == IDLE) |-> !oreq.valid);

endmodule
